// File: rtl/amci_arb_pkg.sv
// amci_arb_pkg: shared FSM state encoding and NUM_REQ legal range for the AMCI arbiter.
package amci_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam int NUM_REQ_MIN = 2;
   localparam int NUM_REQ_MAX = 8;

   function automatic bit num_req_ok(input int n);
      return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
   endfunction

endpackage

// File: rtl/amci_rr_select.sv
// amci_rr_select: combinational winner pick; round-robin from ptr+1, or lowest index
// when AMCI_ARB_FIXED_PRIO_EN is defined.
module amci_rr_select
   import amci_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx
);

   int base;
   int j;

`ifdef AMCI_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;
   assign base = NUM_REQ - 1;
`else
   assign base = int'(ptr);
`endif

   // Scan from the farthest candidate down so the nearest one after base overwrites.
   always_comb begin
      gnt = '0;
      idx = '0;
      j = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = (base + k) % NUM_REQ;
         if (req[j]) begin
            gnt = '0;
            gnt[j] = 1'b1;
            idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/amci_arbiter.sv
// amci_arbiter: serialises NUM_REQ single-beat requesters onto one AMCI master port.
// Define AMCI_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module amci_arbiter
   import amci_arb_pkg::*;
#(
   parameter int NUM_REQ          = 4,
   parameter int C_AXI_ADDR_WIDTH = 32,
   parameter int C_AXI_DATA_WIDTH = 32
) (
   input  logic                                M_AXI_ACLK,
   input  logic                                M_AXI_ARESETN,
   input  logic [NUM_REQ-1:0]                  REQ_VALID,
   input  logic [NUM_REQ-1:0]                  REQ_WRITE,
   input  logic [NUM_REQ*C_AXI_ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [NUM_REQ*C_AXI_DATA_WIDTH-1:0] REQ_WDATA,
   output logic [NUM_REQ-1:0]                  RSP_DONE,
   output logic [C_AXI_DATA_WIDTH-1:0]         RSP_RDATA,
   output logic [NUM_REQ-1:0]                  GRANT,
   output logic [C_AXI_ADDR_WIDTH-1:0]         AMCI_WADDR,
   output logic [C_AXI_DATA_WIDTH-1:0]         AMCI_WDATA,
   output logic                                AMCI_WRITE,
   output logic [C_AXI_ADDR_WIDTH-1:0]         AMCI_RADDR,
   output logic                                AMCI_READ,
   input  logic                                AMCI_WIDLE,
   input  logic                                AMCI_RIDLE,
   input  logic [C_AXI_DATA_WIDTH-1:0]         AMCI_RDATA
);

   localparam int IW = $clog2(NUM_REQ);

   if (!num_req_ok(NUM_REQ)) begin : g_bad_num_req
      $error("amci_arbiter: NUM_REQ must be within 2..8");
   end

   arb_state_t                  state, state_nxt;
   logic [NUM_REQ-1:0]          sel_gnt;
   logic [IW-1:0]               sel_idx;
   logic [IW-1:0]               ptr;
   logic [C_AXI_ADDR_WIDTH-1:0] sel_addr;
   logic [C_AXI_DATA_WIDTH-1:0] sel_wdata;
   logic                        grant_write;
   logic                        go;
   logic                        fin;

   assign sel_addr  = REQ_ADDR[int'(sel_idx)*C_AXI_ADDR_WIDTH +: C_AXI_ADDR_WIDTH];
   assign sel_wdata = REQ_WDATA[int'(sel_idx)*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH];
   assign go        = (state == IDLE) && AMCI_WIDLE && AMCI_RIDLE && (|REQ_VALID);
   assign fin       = (state == WAIT) && (grant_write ? AMCI_WIDLE : AMCI_RIDLE);

   amci_rr_select #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_sel (
      .req (REQ_VALID),
      .ptr (ptr),
      .gnt (sel_gnt),
      .idx (sel_idx)
   );

`ifdef AMCI_ARB_FIXED_PRIO_EN
   logic unused_idx;
   assign unused_idx = ^sel_idx;
   assign ptr = '0;
`else
   logic [IW-1:0] grant_idx;

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         ptr       <= IW'(NUM_REQ - 1);
         grant_idx <= '0;
      end else begin
         if (go) grant_idx <= sel_idx;
         if (state == DONE) ptr <= grant_idx;
      end
   end
`endif

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) state <= IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = go ? ISSUE : IDLE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    state_nxt = fin ? DONE : WAIT;
         default: state_nxt = IDLE;
      endcase
   end

   // Every AMCI/RSP output is a register; nothing reaches the master combinationally.
   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         GRANT       <= '0;
         RSP_DONE    <= '0;
         RSP_RDATA   <= '0;
         AMCI_WRITE  <= 1'b0;
         AMCI_READ   <= 1'b0;
         AMCI_WADDR  <= '0;
         AMCI_RADDR  <= '0;
         AMCI_WDATA  <= '0;
         grant_write <= 1'b0;
      end else begin
         AMCI_WRITE <= 1'b0;
         AMCI_READ  <= 1'b0;
         RSP_DONE   <= '0;
         if (go) begin
            GRANT       <= sel_gnt;
            grant_write <= REQ_WRITE[sel_idx];
            AMCI_WRITE  <= REQ_WRITE[sel_idx];
            AMCI_READ   <= !REQ_WRITE[sel_idx];
            AMCI_WADDR  <= sel_addr;
            AMCI_RADDR  <= sel_addr;
            AMCI_WDATA  <= sel_wdata;
         end
         if (fin) begin
            RSP_DONE <= GRANT;
            if (!grant_write) RSP_RDATA <= AMCI_RDATA;
         end
         if (state == DONE) GRANT <= '0;
      end
   end

endmodule

// File: tb/tb_amci_arbiter.sv
// tb_amci_arbiter: scoreboard bench for amci_arbiter with a behavioural AMCI master and slave memory.
module tb_amci_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct packed {
      logic [N-1:0]  done;
      logic [DW-1:0] rdata;
   } exp_t;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [N-1:0]    req_valid, req_write;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    rsp_done, grant;
   logic [DW-1:0]   rsp_rdata;
   logic [AW-1:0]   amci_waddr, amci_raddr;
   logic [DW-1:0]   amci_wdata;
   logic            amci_write, amci_read;
   logic            m_widle = 1'b1, m_ridle = 1'b1, force_wbusy = 1'b0;
   logic [DW-1:0]   m_rdata = '0, m_pend = '0;
   int              m_cnt = 0, m_lat = 2;

   exp_t            exp_q[$];
   logic [DW-1:0]   ref_mem[logic [AW-1:0]];
   logic [DW-1:0]   last_rd = '0;
   int              checks = 0, failures = 0;
   int              w_pulses = 0, r_pulses = 0;
   logic [AW-1:0]   w_addr = '0, r_addr = '0;
   logic [DW-1:0]   w_data = '0;

`ifdef AMCI_ARB_FIXED_PRIO_EN
   int rr_order[6]   = '{0, 0, 0, 0, 0, 0};
   int pair_order[4] = '{1, 1, 1, 1};
`else
   int rr_order[6]   = '{0, 1, 2, 3, 0, 1};
   int pair_order[4] = '{1, 3, 1, 3};
`endif

   always #5 clk = ~clk;

   amci_arbiter #(
      .NUM_REQ          (N),
      .C_AXI_ADDR_WIDTH (AW),
      .C_AXI_DATA_WIDTH (DW)
   ) dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESETN (rstn),
      .REQ_VALID     (req_valid),
      .REQ_WRITE     (req_write),
      .REQ_ADDR      (req_addr),
      .REQ_WDATA     (req_wdata),
      .RSP_DONE      (rsp_done),
      .RSP_RDATA     (rsp_rdata),
      .GRANT         (grant),
      .AMCI_WADDR    (amci_waddr),
      .AMCI_WDATA    (amci_wdata),
      .AMCI_WRITE    (amci_write),
      .AMCI_RADDR    (amci_raddr),
      .AMCI_READ     (amci_read),
      .AMCI_WIDLE    (m_widle & !force_wbusy),
      .AMCI_RIDLE    (m_ridle),
      .AMCI_RDATA    (m_rdata)
   );

   function automatic logic [DW-1:0] slave_init(input logic [AW-1:0] a);
      return (a == 32'h20) ? 32'h1234_5678 : (32'h1000_0000 | a);
   endfunction

   // Master: flags drop the cycle after a pulse and return after m_lat cycles.
   logic [DW-1:0] mem[logic [AW-1:0]];
   always @(posedge clk) begin
      if (!rstn) begin
         m_widle <= 1'b1;
         m_ridle <= 1'b1;
         m_cnt   <= 0;
      end else if (amci_write) begin
         mem[amci_waddr] = amci_wdata;
         m_widle <= 1'b0;
         m_cnt   <= m_lat;
      end else if (amci_read) begin
         m_pend  <= mem.exists(amci_raddr) ? mem[amci_raddr] : slave_init(amci_raddr);
         m_ridle <= 1'b0;
         m_cnt   <= m_lat;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_widle <= 1'b1;
            m_ridle <= 1'b1;
            m_rdata <= m_pend;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic post(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i]          = w;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      req_valid[i]          = 1'b1;
   endtask

   task automatic expect_rsp(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      if (w) ref_mem[a] = d;
      else last_rd = ref_mem.exists(a) ? ref_mem[a] : slave_init(a);
      e.done    = '0;
      e.done[i] = 1'b1;
      e.rdata   = last_rd;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n, input logic [N-1:0] hold, input bit drop_on_grant);
      exp_t e;
      int   got = 0;
      for (int cyc = 0; cyc < 100 * n && got < n; cyc++) begin
         @(negedge clk);
         if (amci_write) begin
            w_pulses++;
            w_addr = amci_waddr;
            w_data = amci_wdata;
         end
         if (amci_read) begin
            r_pulses++;
            r_addr = amci_raddr;
         end
         if (drop_on_grant && grant != 0) req_valid = req_valid & ~grant;
         if (rsp_done != 0) begin
            got++;
            if (exp_q.size() == 0) check("unexpected_done", rsp_done, 0);
            else begin
               e = exp_q.pop_front();
               check("done_vec", rsp_done, e.done);
               check("rsp_rdata", rsp_rdata, e.rdata);
            end
            req_valid = req_valid & ~(rsp_done & ~hold);
         end
      end
      check("done_count", got, n);
      @(negedge clk);
      check("done_one_cycle", rsp_done, 0);
      req_valid = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_done", rsp_done, 0);
      check("rst_grant", grant, 0);
      check("rst_write", amci_write, 0);
      check("rst_read", amci_read, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_waddr", amci_waddr, 0);
      check("rst_raddr", amci_raddr, 0);
      check("rst_wdata", amci_wdata, 0);
      rstn = 1'b1;
      @(negedge clk);

      post(2, 1'b1, 32'h10, 32'hDEAD_BEEF);
      expect_rsp(2, 1'b1, 32'h10, 32'hDEAD_BEEF);
      run(1, '0, 1'b0);
      check("wr_pulses", w_pulses, 1);
      check("wr_addr", w_addr, 32'h10);
      check("wr_data", w_data, 32'hDEAD_BEEF);
      check("wr_no_read", r_pulses, 0);

      w_pulses = 0;
      m_lat    = 3;
      post(0, 1'b0, 32'h20, '0);
      expect_rsp(0, 1'b0, 32'h20, '0);
      run(1, '0, 1'b0);
      check("rd_pulses", r_pulses, 1);
      check("rd_addr", r_addr, 32'h20);
      check("rd_no_write", w_pulses, 0);

      post(1, 1'b1, 32'h30, 32'hA5A5_0001);
      expect_rsp(1, 1'b1, 32'h30, 32'hA5A5_0001);
      run(1, '0, 1'b0);

      post(3, 1'b0, 32'h10, '0);
      expect_rsp(3, 1'b0, 32'h10, '0);
      run(1, '0, 1'b1);

      m_lat = 1;
      for (int i = 0; i < N; i++) post(i, 1'b0, 32'h40 + 4 * i, '0);
      for (int k = 0; k < 6; k++) expect_rsp(rr_order[k], 1'b0, 32'h40 + 4 * rr_order[k], '0);
      run(6, '1, 1'b0);

      force_wbusy = 1'b1;
      post(2, 1'b0, 32'h44, '0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("busy_no_grant", grant, 0);
      end
      force_wbusy = 1'b0;
      @(negedge clk);
      check("busy_grant", grant, 4'b0100);
      expect_rsp(2, 1'b0, 32'h44, '0);
      run(1, '0, 1'b0);

      m_lat = 8;
      post(3, 1'b1, 32'h50, 32'h77);
      for (int k = 0; k < 20 && !amci_write; k++) @(negedge clk);
      check("rst_issue_seen", amci_write, 1);
      @(negedge clk);
      check("rst_wait_grant", grant, 4'b1000);
      rstn      = 1'b0;
      req_valid = '0;
      @(negedge clk);
      check("midrst_grant", grant, 0);
      check("midrst_done", rsp_done, 0);
      check("midrst_write", amci_write, 0);
      check("midrst_read", amci_read, 0);
      check("midrst_rdata", rsp_rdata, 0);
      rstn    = 1'b1;
      last_rd = '0;
      m_lat   = 2;
      @(negedge clk);

      for (int i = 0; i < N; i++) post(i, 1'b1, 32'h60 + 4 * i, 32'hC0 + i);
      for (int i = 0; i < N; i++) expect_rsp(i, 1'b1, 32'h60 + 4 * i, 32'hC0 + i);
      run(4, '0, 1'b0);

      post(1, 1'b0, 32'h20, '0);
      post(3, 1'b0, 32'h24, '0);
      for (int k = 0; k < 4; k++) expect_rsp(pair_order[k], 1'b0, 32'h20 + 4 * (pair_order[k] / 3), '0);
      run(4, 4'b1010, 1'b0);
      check("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
